imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered RISC-V immediate/format decode stage; generalises the single-format J-type decoder to every base format (I, S, B, U, J).
- Parametrised in XLEN; computes PC-relative targets.
- Sits between fetch and register-read with a valid/ready handshake and a 2-entry skid buffer, so backpressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extended to XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; asserted when state != FULL
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  out_* fields hold a decoded entry
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  decoded immediate
- out_rd  out  5  destination register
- out_fmt  out  3  format code (package enum)
- out_target  out  XLEN  pc+imm for B, J, AUIPC; 0 otherwise
- out_illegal  out  1  unrecognised opcode or instr[1:0] != 2'b11

Behaviour:
- Reset (async, rst_n low): state EMPTY; out_valid=0; out_imm, out_rd, out_fmt, out_target, out_illegal = 0; in_ready=1.
- Transfers: input when in_valid&&in_ready; output when out_valid&&out_ready.
- Latency: 1 cycle from accepted input to out_valid when the stage was empty.
- States: EMPTY (0 entries), ONE (main reg valid), FULL (main + skid valid).
  - EMPTY: in xfer -> ONE.
  - ONE: in xfer without out xfer -> FULL (new entry into skid); out xfer without in xfer -> EMPTY; both -> ONE (main reloaded).
  - FULL: in_ready=0; out xfer -> ONE (skid moves to main).
- Ordering: strict FIFO; outputs drive from the main register only.
- Output stability: outputs stay stable while out_valid && !out_ready.
- Flush: next state EMPTY regardless of other inputs; any input presented in the flush cycle is dropped; out_valid=0 next cycle.
- Reset mid-operation: all entries lost immediately; no partial output.
- Decode is combinational on the input side; results are registered in main/skid.
- Opcode map:
  - I: 0000011, 0010011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111 (LUI), 0010111 (AUIPC)
  - J: 1101111
- Immediates (sext to XLEN):
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - U: {instr[31:12],12'b0} (sign-extended on XLEN=64)
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
- out_rd: instr[11:7] for I/U/J; 0 for S/B.
- Illegal: fmt=NONE, imm=0, rd=0, target=0, out_illegal=1; the entry still flows through the handshake.
- Target: (pc + imm) mod 2^XLEN; wrap-around silent. JALR target is 0 (needs rs1).

Decomposition:
- Package imm_decode_pkg:
  - fmt enum: NONE=0, I=1, S=2, B=3, U=4, J=5
  - opcode localparams
  - packed entry struct {imm, rd, fmt, target, illegal}
- Sub-module imm_gen: purely combinational instr+pc -> entry. The stage instantiates it once and holds main/skid entries plus the FSM.

Test Plan:
- XLEN=32, JAL 0x001000EF at pc 0x00001000, out_ready=1 -> next cycle out_valid=1, imm=0x00000800, rd=1, fmt=J, target=0x00001800.
- BEQ 0xFE000EE3 at pc 0x00000000 -> imm=0xFFFFFFFC, rd=0, fmt=B, target=0xFFFFFFFC (wrap).
- XLEN=64, LUI 0x800002B7 -> imm=0xFFFFFFFF80000000, rd=5, fmt=U, target=0.
- Backpressure: out_ready=0, present three instrs back-to-back -> first two accepted, in_ready=0 from the cycle after the second, third held. Raise out_ready -> all three emerge in order, none duplicated.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- instr 0x00000000 -> out_illegal=1, fmt=NONE, imm=0. rst_n pulsed low while ONE -> out_valid=0 immediately (async), all outputs 0.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared types for the immediate/format decode stage: format codes,
// base opcodes and the decoded entry held in the stage registers.
package imm_decode_pkg;

    // Entries are stored at the widest legal XLEN; narrower instances
    // use the low XLEN bits only.
    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        logic [4:0]          rd;
        fmt_e                fmt;
        logic [MAX_XLEN-1:0] target;
        logic                illegal;
    } entry_t;

endpackage

// File: rtl/imm_decode_stage_imm_gen.sv
// Combinational RISC-V immediate/format decoder: instruction + PC in,
// decoded entry (immediate, rd, format, PC-relative target) out.
module imm_gen
    import imm_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output entry_t          entry
);

    logic [MAX_XLEN-1:0] imm64;
    logic [XLEN-1:0]     imm_x;
    logic [XLEN-1:0]     target_x;
    logic                use_target;

    // Decode the opcode, build the sign-extended immediate and the target
    always_comb begin
        entry      = '0;
        imm64      = '0;
        use_target = 1'b0;
        if (instr[1:0] != 2'b11) begin
            entry.illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_OPIMM, OP_JALR: begin
                    entry.fmt = FMT_I;
                    entry.rd  = instr[11:7];
                    imm64     = {{52{instr[31]}}, instr[31:20]};
                end
                OP_STORE: begin
                    entry.fmt = FMT_S;
                    imm64     = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OP_BRANCH: begin
                    entry.fmt  = FMT_B;
                    imm64      = {{52{instr[31]}}, instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
                    use_target = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    entry.fmt  = FMT_U;
                    entry.rd   = instr[11:7];
                    imm64      = {{32{instr[31]}}, instr[31:12], 12'b0};
                    use_target = (instr[6:0] == OP_AUIPC);
                end
                OP_JAL: begin
                    entry.fmt  = FMT_J;
                    entry.rd   = instr[11:7];
                    imm64      = {{44{instr[31]}}, instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
                    use_target = 1'b1;
                end
                default: entry.illegal = 1'b1;
            endcase
        end
        imm_x        = imm64[XLEN-1:0];
        target_x     = pc + imm_x;
        entry.imm    = imm64;
        entry.target = use_target ? MAX_XLEN'(target_x) : '0;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate/format decode stage with a valid/ready handshake
// and a two-entry (main + skid) buffer. Outputs come from main only.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    logic   in_xfer;
    logic   out_xfer;
    logic   unused_hi;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .pc    (in_pc),
        .entry (dec)
    );

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy transitions; flush overrides everything and drops the input
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_d  = dec;
                    state_d = FULL;
                end else if (out_xfer && !in_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    main_d  = dec;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // State and entry registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_rd      = main_q.rd;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target[XLEN-1:0];
    assign out_illegal = main_q.illegal;

    // Upper entry bits are meaningless when XLEN is below MAX_XLEN
    assign unused_hi = ^{main_q.imm, main_q.target};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: 32- and 64-bit instances,
// directed vectors with hand-computed decode results.
module tb_imm_decode_stage;
    import imm_decode_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [2:0]  fmt;
        logic [63:0] target;
        logic        illegal;
    } exp_t;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;
    exp_t sb32[$];
    exp_t sb64[$];

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    logic [4:0]  out_rd;
    logic [2:0]  out_fmt;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_illegal_w;
    logic [31:0] in_instr_w;
    logic [63:0] in_pc_w, out_imm_w, out_target_w;
    logic [4:0]  out_rd_w;
    logic [2:0]  out_fmt_w;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_rd(out_rd),
        .out_fmt(out_fmt), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w), .in_pc(in_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_imm(out_imm_w), .out_rd(out_rd_w),
        .out_fmt(out_fmt_w), .out_target(out_target_w), .out_illegal(out_illegal_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(logic [63:0] imm, logic [4:0] rd, fmt_e fmt,
                                logic [63:0] target, logic illegal);
        exp_t e;
        e.imm = imm; e.rd = rd; e.fmt = fmt; e.target = target; e.illegal = illegal;
        return e;
    endfunction

    // 32-bit monitor: pops on every output transfer, checks hold stability
    logic        hold32 = 1'b0;
    logic [72:0] held32;
    always @(negedge clk) begin
        exp_t e;
        if (hold32 && out_valid) begin
            ncmp++;
            if ({out_imm, out_rd, out_fmt, out_target, out_illegal} !== held32) begin
                nerr++;
                $display("FAIL hold32: got 0x%0h, expected 0x%0h",
                         {out_imm, out_rd, out_fmt, out_target, out_illegal}, held32);
            end
        end
        hold32 = out_valid && !out_ready;
        held32 = {out_imm, out_rd, out_fmt, out_target, out_illegal};
        if (out_valid && out_ready) begin
            if (sb32.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL out32_unexpected: got entry imm 0x%0h, expected no output", out_imm);
            end else begin
                e = sb32.pop_front();
                check("imm32", 64'(out_imm), 64'(e.imm[31:0]));
                check("rd32", 64'(out_rd), 64'(e.rd));
                check("fmt32", 64'(out_fmt), 64'(e.fmt));
                check("target32", 64'(out_target), 64'(e.target[31:0]));
                check("illegal32", 64'(out_illegal), 64'(e.illegal));
            end
        end
    end

    // 64-bit monitor
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_w && out_ready_w) begin
            if (sb64.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL out64_unexpected: got entry imm 0x%0h, expected no output", out_imm_w);
            end else begin
                e = sb64.pop_front();
                check("imm64", out_imm_w, e.imm);
                check("rd64", 64'(out_rd_w), 64'(e.rd));
                check("fmt64", 64'(out_fmt_w), 64'(e.fmt));
                check("target64", out_target_w, e.target);
                check("illegal64", 64'(out_illegal_w), 64'(e.illegal));
            end
        end
    end

    task automatic send32(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        int unsigned n = 0;
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            ncmp++; nerr++;
            $display("FAIL send32_timeout: got in_ready=0, expected 1 within 60 cycles");
            in_valid = 1'b0;
        end else begin
            sb32.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send64(input logic [31:0] instr, input logic [63:0] pc, input exp_t e);
        int unsigned n = 0;
        in_valid_w = 1'b1; in_instr_w = instr; in_pc_w = pc;
        @(negedge clk);
        while (!in_ready_w && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_w) begin
            ncmp++; nerr++;
            $display("FAIL send64_timeout: got in_ready=0, expected 1 within 60 cycles");
            in_valid_w = 1'b0;
        end else begin
            sb64.push_back(e);
            @(posedge clk);
            #1 in_valid_w = 1'b0;
        end
    endtask

    task automatic drain(input bit wide);
        int unsigned n = 0;
        while ((wide ? sb64.size() : sb32.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        ncmp++;
        if ((wide ? sb64.size() : sb32.size()) != 0) begin
            nerr++;
            $display("FAIL drain: got %0d entries outstanding, expected 0",
                     wide ? sb64.size() : sb32.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        in_valid_w = 1'b0; in_instr_w = '0; in_pc_w = '0; out_ready_w = 1'b0;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({out_imm, out_rd, out_fmt, out_illegal}), 64'd0);
        check("rst_target", 64'(out_target), 64'd0);
        check("rst_out_valid64", 64'(out_valid_w), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Streaming decode, all formats
        send32(32'h001000EF, 32'h00001000, mk(64'h800, 5'd1, FMT_J, 64'h1800, 1'b0));
        check("latency32", 64'(out_valid), 64'd1);
        send32(32'hFE000EE3, 32'h00000000, mk(64'hFFFFFFFC, 5'd0, FMT_B, 64'hFFFFFFFC, 1'b0));
        send32(32'hFFF00113, 32'h00000010, mk(64'hFFFFFFFF, 5'd2, FMT_I, 64'h0, 1'b0));
        send32(32'h00A12223, 32'h00000020, mk(64'h4, 5'd0, FMT_S, 64'h0, 1'b0));
        send32(32'h12345197, 32'h00000100, mk(64'h12345000, 5'd3, FMT_U, 64'h12345100, 1'b0));
        send32(32'h800002B7, 32'h00000200, mk(64'h80000000, 5'd5, FMT_U, 64'h0, 1'b0));
        send32(32'hFFDFF06F, 32'h00002000, mk(64'hFFFFFFFC, 5'd0, FMT_J, 64'h1FFC, 1'b0));
        send32(32'h010280E7, 32'h00003000, mk(64'h10, 5'd1, FMT_I, 64'h0, 1'b0));
        send32(32'hFF80A383, 32'h00004000, mk(64'hFFFFFFF8, 5'd7, FMT_I, 64'h0, 1'b0));
        send32(32'h00000000, 32'h00000040, mk(64'h0, 5'd0, FMT_NONE, 64'h0, 1'b1));
        send32(32'h00000012, 32'h00000050, mk(64'h0, 5'd0, FMT_NONE, 64'h0, 1'b1));
        drain(1'b0);

        // Backpressure: two accepted, third stalls until out_ready rises
        out_ready = 1'b0;
        fork
            begin
                send32(32'hFFF00113, 32'h00000300, mk(64'hFFFFFFFF, 5'd2, FMT_I, 64'h0, 1'b0));
                send32(32'h00A12223, 32'h00000304, mk(64'h4, 5'd0, FMT_S, 64'h0, 1'b0));
                check("bp_full_ready", 64'(in_ready), 64'd0);
                send32(32'h12345197, 32'h00000308, mk(64'h12345000, 5'd3, FMT_U, 64'h12345308, 1'b0));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_head", 64'(out_imm), 64'hFFFFFFFF);
                out_ready = 1'b1;
            end
        join
        drain(1'b0);

        // Flush while FULL with a pending input
        out_ready = 1'b0;
        send32(32'h001000EF, 32'h00001000, mk(64'h800, 5'd1, FMT_J, 64'h1800, 1'b0));
        send32(32'hFE000EE3, 32'h00000000, mk(64'hFFFFFFFC, 5'd0, FMT_B, 64'hFFFFFFFC, 1'b0));
        in_valid = 1'b1; in_instr = 32'h800002B7; in_pc = '0; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        sb32.delete();
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_ready", 64'(in_ready), 64'd1);

        // Flush while ONE: an acceptable input in the flush cycle is dropped
        send32(32'hFFF00113, 32'h00000010, mk(64'hFFFFFFFF, 5'd2, FMT_I, 64'h0, 1'b0));
        in_valid = 1'b1; in_instr = 32'h00A12223; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        sb32.delete();
        check("flush_one_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send32(32'h00000000, 32'h00000060, mk(64'h0, 5'd0, FMT_NONE, 64'h0, 1'b1));
        drain(1'b0);

        // 64-bit instance: sign extension of U immediates, wide targets
        out_ready_w = 1'b1;
        send64(32'h800002B7, 64'h0, mk(64'hFFFFFFFF80000000, 5'd5, FMT_U, 64'h0, 1'b0));
        send64(32'h12345197, 64'h0000000100000000, mk(64'h12345000, 5'd3, FMT_U, 64'h0000000112345000, 1'b0));
        send64(32'hFE000EE3, 64'h0, mk(64'hFFFFFFFFFFFFFFFC, 5'd0, FMT_B, 64'hFFFFFFFFFFFFFFFC, 1'b0));
        drain(1'b1);

        // Asynchronous reset while holding one entry
        out_ready = 1'b0;
        send32(32'h001000EF, 32'h00001000, mk(64'h800, 5'd1, FMT_J, 64'h1800, 1'b0));
        sb32.delete();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_outputs", 64'({out_imm, out_rd, out_fmt, out_illegal}), 64'd0);
        check("arst_target", 64'(out_target), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        send32(32'h00A12223, 32'h00000020, mk(64'h4, 5'd0, FMT_S, 64'h0, 1'b0));
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
